fifo_wr_ctrl: RTL and testbench
===============================

# fifo_wr_ctrl

Parametrised write-side controller for the asynchronous FIFO, in the write clock domain. It drives the memory write enable and address and produces the Gray write pointer for the read-domain synchroniser. From the synchronised read pointer it derives full, a programmable almost-full flag and an occupancy count. It also flags and counts writes rejected while full.

## Interface
- ADDR_SIZE, default 3: address width; depth = 2^ADDR_SIZE entries; legal range ≥ 2.
- DROP_W, default 8: width of the rejected-write counter; ≥ 1.

Ports:
- w_Clk  in  1  write-domain clock, all state updates on rising edge.
- w_Rst  in  1  reset, asynchronous, active-low.
- w_Inc  in  1  write request for the current cycle.
- wsync_Rptr  in  ADDR_SIZE+1  Gray read pointer, already synchronised into w_Clk.
- af_Thresh  in  ADDR_SIZE+1  almost-full threshold in entries, quasi-static.
- ovf_Clr  in  1  clears w_Overflow and w_DropCnt.
- w_En  out  1  memory write strobe (combinational) = w_Inc & ~fifo_Full.
- w_Addr  out  ADDR_SIZE  memory write address = low ADDR_SIZE bits of the binary write counter.
- w_Ptr  out  ADDR_SIZE+1  registered Gray write pointer, to the read-domain synchroniser.
- fifo_Full  out  1  registered full flag.
- almost_Full  out  1  registered, level ≥ af_Thresh.
- w_Level  out  ADDR_SIZE+1  registered occupancy, range 0..2^ADDR_SIZE.
- w_Overflow  out  1  sticky, set by a rejected write.
- w_DropCnt  out  DROP_W  saturating count of rejected writes.

## Operation
- State: binary counter w_Bin (ADDR_SIZE+1 bits), w_Ptr, fifo_Full, almost_Full, w_Level, w_Overflow, w_DropCnt.
- Reset values (all outputs): w_Bin=0, w_Ptr=0, w_Addr=0, fifo_Full=0, almost_Full=(af_Thresh==0), w_Level=0, w_Overflow=0, w_DropCnt=0.
- Accept: w_En=1 → next_bin = w_Bin+1, mod 2^(ADDR_SIZE+1); otherwise next_bin = w_Bin.
- Gray conversion: next_gray = (next_bin>>1) ^ next_bin. Registers load w_Bin<=next_bin and w_Ptr<=next_gray.
- Read pointer: r_bin = Gray-to-binary of wsync_Rptr, using an XOR prefix from the MSB.
- Full: fifo_Full <= (next_gray == {~wsync_Rptr[MSB:MSB-1], wsync_Rptr[MSB-2:0]}).
- Level: w_Level <= (next_bin − r_bin) mod 2^(ADDR_SIZE+1).
- Almost full: almost_Full <= (same level value ≥ af_Thresh), unsigned compare.
- Reject: w_Inc=1 while fifo_Full=1. The write is dropped, and the pointer and address do not change.
  - Sets w_Overflow on the next edge.
  - Increments w_DropCnt, saturating at all-ones.
- Clear: ovf_Clr=1 clears w_Overflow and w_DropCnt. If a reject occurs in the same cycle, the set wins: w_Overflow=1 and w_DropCnt=1.
- Wrap-around: the extra MSB distinguishes full from empty. Counter rollover from all-ones to 0 is normal operation.
- Flags and level are pessimistic; the read pointer lags by synchroniser latency.
  - Full and almost_Full may stay asserted after a read, never deassert early.
  - w_Level never under-reports.

## Timing
- Accepted write in cycle t: w_Addr and w_Ptr show the new value from t+1.
- Write that fills the FIFO in cycle t: fifo_Full=1 from t+1. There is no cycle where an accepted write overwrites unread data.
- A wsync_Rptr change in cycle t is reflected in fifo_Full, almost_Full and w_Level at t+1.
- Reject in cycle t: w_Overflow and w_DropCnt update at t+1.
- w_En is combinational from w_Inc and registered fifo_Full, with zero latency.
- w_Rst asserted mid-operation: all state returns to reset values immediately, without waiting for w_Clk. The read side is reset separately.

## Test plan
- Reset check:
  - Stimulus: assert w_Rst=0 asynchronously mid-burst.
  - Required: every output goes to its reset value with no w_Clk edge; after release, the first write uses w_Addr=0.
- Fill (ADDR_SIZE=3, wsync_Rptr=0, af_Thresh=6):
  - Stimulus: 8 consecutive writes.
  - Required: almost_Full=1 after the 6th write, fifo_Full=1 after the 8th, w_Level=8, w_Ptr=4'b1100, w_Addr=0.
- Overflow:
  - Stimulus: while full, w_Inc=1 for 3 cycles.
  - Required: w_En=0, w_Ptr held, w_Overflow=1, w_DropCnt=3.
  - Then: ovf_Clr with one more reject in the same cycle gives w_Overflow=1, w_DropCnt=1.
- Wrap-around:
  - Stimulus: from full, drive wsync_Rptr=4'b1100, then do 8 more writes.
  - Required: fifo_Full=0 and w_Level=0 one cycle after the pointer change; after the 8 writes, w_Ptr=4'b0000, fifo_Full=1, w_Level=8.
- Saturation (DROP_W=2):
  - Stimulus: 5 rejected writes.
  - Required: w_DropCnt stops at 3.
- Simultaneous events:
  - Stimulus: a write in the same cycle the read pointer advances by one, at level 7.
  - Required: w_Level stays 7, fifo_Full=0.

Source files
------------

// File: rtl/fifo_wr_ctrl_if.sv
// Write-side bus of the async FIFO: request, read-pointer feedback, memory strobe and status.
// master drives requests and the synchronised read pointer, slave is the write controller.
interface fifo_wr_ctrl_if #(
    parameter int unsigned ADDR_SIZE = 3,
    parameter int unsigned DROP_W    = 8
);
    logic                  w_Inc;
    logic [ADDR_SIZE:0]    wsync_Rptr;
    logic [ADDR_SIZE:0]    af_Thresh;
    logic                  ovf_Clr;
    logic                  w_En;
    logic [ADDR_SIZE-1:0]  w_Addr;
    logic [ADDR_SIZE:0]    w_Ptr;
    logic                  fifo_Full;
    logic                  almost_Full;
    logic [ADDR_SIZE:0]    w_Level;
    logic                  w_Overflow;
    logic [DROP_W-1:0]     w_DropCnt;

    modport master (
        output w_Inc, wsync_Rptr, af_Thresh, ovf_Clr,
        input  w_En, w_Addr, w_Ptr, fifo_Full, almost_Full, w_Level, w_Overflow, w_DropCnt
    );

    modport slave (
        input  w_Inc, wsync_Rptr, af_Thresh, ovf_Clr,
        output w_En, w_Addr, w_Ptr, fifo_Full, almost_Full, w_Level, w_Overflow, w_DropCnt
    );
endinterface

// File: rtl/fifo_wr_ctrl.sv
// Async FIFO write-side controller: binary/Gray write pointer, full, almost-full, occupancy
// and rejected-write tracking, all in the write clock domain.
module fifo_wr_ctrl #(
    parameter int unsigned ADDR_SIZE = 3,
    parameter int unsigned DROP_W    = 8
) (
    input logic           w_Clk,
    input logic           w_Rst,
    fifo_wr_ctrl_if.slave bus
);
    localparam int unsigned PW = ADDR_SIZE + 1;

    logic [PW-1:0]     w_bin_q, w_ptr_q, w_level_q;
    logic              fifo_full_q, almost_full_q, w_overflow_q;
    logic [DROP_W-1:0] w_drop_cnt_q;

    logic              w_en, reject;
    logic [PW-1:0]     next_bin, next_gray, r_bin, full_ptr, next_level;

    assign w_en       = bus.w_Inc & ~fifo_full_q;
    assign reject     = bus.w_Inc & fifo_full_q;
    assign next_bin   = w_bin_q + PW'(w_en);
    assign next_gray  = (next_bin >> 1) ^ next_bin;
    assign next_level = next_bin - r_bin;
    // Full when the write pointer has lapped the read pointer exactly once.
    assign full_ptr   = {~bus.wsync_Rptr[PW-1:PW-2], bus.wsync_Rptr[PW-3:0]};

    always_comb begin
        r_bin = '0;
        for (int i = 0; i < int'(PW); i++) begin
            r_bin[i] = ^(bus.wsync_Rptr >> i);
        end
    end

    always_ff @(posedge w_Clk or negedge w_Rst) begin
        if (!w_Rst) begin
            w_bin_q       <= '0;
            w_ptr_q       <= '0;
            w_level_q     <= '0;
            fifo_full_q   <= 1'b0;
            almost_full_q <= (bus.af_Thresh == '0);
            w_overflow_q  <= 1'b0;
            w_drop_cnt_q  <= '0;
        end else begin
            w_bin_q       <= next_bin;
            w_ptr_q       <= next_gray;
            w_level_q     <= next_level;
            fifo_full_q   <= (next_gray == full_ptr);
            almost_full_q <= (next_level >= bus.af_Thresh);
            // A reject in the same cycle as a clear restarts the count at one.
            if (reject) begin
                w_overflow_q <= 1'b1;
                if (bus.ovf_Clr) begin
                    w_drop_cnt_q <= DROP_W'(1);
                end else if (w_drop_cnt_q != '1) begin
                    w_drop_cnt_q <= w_drop_cnt_q + DROP_W'(1);
                end
            end else if (bus.ovf_Clr) begin
                w_overflow_q <= 1'b0;
                w_drop_cnt_q <= '0;
            end
        end
    end

    assign bus.w_En        = w_en;
    assign bus.w_Addr      = w_bin_q[ADDR_SIZE-1:0];
    assign bus.w_Ptr       = w_ptr_q;
    assign bus.fifo_Full   = fifo_full_q;
    assign bus.almost_Full = almost_full_q;
    assign bus.w_Level     = w_level_q;
    assign bus.w_Overflow  = w_overflow_q;
    assign bus.w_DropCnt   = w_drop_cnt_q;
endmodule

// File: tb/tb_fifo_wr_ctrl.sv
// Bench for fifo_wr_ctrl: directed scenarios with literal expectations, then random traffic
// checked every cycle against an occupancy-based model.
module tb_fifo_wr_ctrl;
    localparam int AS    = 3;
    localparam int DW    = 2;
    localparam int MOD   = 16;
    localparam int DEPTH = 8;
    localparam int SAT   = 3;

    logic w_Clk = 1'b0;
    logic w_Rst = 1'b0;
    fifo_wr_ctrl_if #(.ADDR_SIZE(AS), .DROP_W(DW)) bus ();

    fifo_wr_ctrl #(.ADDR_SIZE(AS), .DROP_W(DW)) dut (
        .w_Clk (w_Clk),
        .w_Rst (w_Rst),
        .bus   (bus)
    );

    always #5 w_Clk = ~w_Clk;

    int n_checks = 0;
    int n_err    = 0;
    bit check_en = 1'b0;

    // Model state: counts of writes and reads, with derived occupancy.
    int m_wcnt, m_level, m_drop, rbin;
    bit m_full, m_af, m_ovf;

    function automatic int gray(input int b);
        return b ^ (b >> 1);
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    always @(posedge w_Clk or negedge w_Rst) begin
        if (!w_Rst) begin
            m_wcnt = 0; m_level = 0; m_full = 0; m_ovf = 0; m_drop = 0;
            m_af = (bus.af_Thresh == 0);
        end else begin
            bit acc, rej;
            acc = bus.w_Inc && !m_full;
            rej = bus.w_Inc && m_full;
            m_wcnt  = (m_wcnt + int'(acc)) % MOD;
            m_level = (m_wcnt - rbin + MOD) % MOD;
            m_full  = (m_level == DEPTH);
            m_af    = (m_level >= int'(bus.af_Thresh));
            if (rej) begin
                m_ovf  = 1;
                m_drop = bus.ovf_Clr ? 1 : ((m_drop + 1 > SAT) ? SAT : m_drop + 1);
            end else if (bus.ovf_Clr) begin
                m_ovf  = 0;
                m_drop = 0;
            end
        end
    end

    always @(negedge w_Clk) begin
        if (check_en) begin
            chk("cyc_en",    int'(bus.w_En),        int'(bus.w_Inc && !m_full));
            chk("cyc_addr",  int'(bus.w_Addr),      m_wcnt % DEPTH);
            chk("cyc_ptr",   int'(bus.w_Ptr),       gray(m_wcnt));
            chk("cyc_full",  int'(bus.fifo_Full),   int'(m_full));
            chk("cyc_af",    int'(bus.almost_Full), int'(m_af));
            chk("cyc_level", int'(bus.w_Level),     m_level);
            chk("cyc_ovf",   int'(bus.w_Overflow),  int'(m_ovf));
            chk("cyc_drop",  int'(bus.w_DropCnt),   m_drop);
        end
    end

    task automatic step();
        @(posedge w_Clk);
        #1;
    endtask

    task automatic set_rptr(input int b);
        rbin = b % MOD;
        bus.wsync_Rptr = 4'(gray(rbin));
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_addr"},  int'(bus.w_Addr),      0);
        chk({tag, "_ptr"},   int'(bus.w_Ptr),       0);
        chk({tag, "_full"},  int'(bus.fifo_Full),   0);
        chk({tag, "_af"},    int'(bus.almost_Full), 0);
        chk({tag, "_level"}, int'(bus.w_Level),     0);
        chk({tag, "_ovf"},   int'(bus.w_Overflow),  0);
        chk({tag, "_drop"},  int'(bus.w_DropCnt),   0);
    endtask

    initial begin
        bus.w_Inc = 0;
        bus.ovf_Clr = 0;
        bus.af_Thresh = 4'd6;
        set_rptr(0);
        #22;
        chk_reset("rst0");
        w_Rst = 1'b1;
        check_en = 1'b1;
        step();

        // Fill: 8 writes with the reader idle.
        bus.w_Inc = 1;
        for (int i = 0; i < 8; i++) begin
            step();
            if (i == 4) chk("fill_af5", int'(bus.almost_Full), 0);
            if (i == 5) chk("fill_af6", int'(bus.almost_Full), 1);
        end
        chk("fill_full",  int'(bus.fifo_Full), 1);
        chk("fill_level", int'(bus.w_Level),   8);
        chk("fill_ptr",   int'(bus.w_Ptr),     12);
        chk("fill_addr",  int'(bus.w_Addr),    0);

        // Overflow: three rejects, then reject-with-clear.
        chk("ovf_en", int'(bus.w_En), 0);
        for (int i = 0; i < 3; i++) step();
        chk("ovf_ptr",  int'(bus.w_Ptr),      12);
        chk("ovf_flag", int'(bus.w_Overflow), 1);
        chk("ovf_cnt",  int'(bus.w_DropCnt),  3);
        bus.ovf_Clr = 1;
        step();
        chk("clrrej_flag", int'(bus.w_Overflow), 1);
        chk("clrrej_cnt",  int'(bus.w_DropCnt),  1);
        bus.ovf_Clr = 0;

        // Saturation: five more rejects on a 2-bit counter.
        for (int i = 0; i < 5; i++) step();
        chk("sat_cnt", int'(bus.w_DropCnt), 3);
        bus.w_Inc = 0;
        bus.ovf_Clr = 1;
        step();
        chk("clr_flag", int'(bus.w_Overflow), 0);
        chk("clr_cnt",  int'(bus.w_DropCnt),  0);
        bus.ovf_Clr = 0;

        // Wrap-around: reader catches up, then 8 writes roll the counter to 0.
        set_rptr(8);
        step();
        chk("wrap_full0",  int'(bus.fifo_Full), 0);
        chk("wrap_level0", int'(bus.w_Level),   0);
        bus.w_Inc = 1;
        for (int i = 0; i < 8; i++) step();
        chk("wrap_ptr",   int'(bus.w_Ptr),     0);
        chk("wrap_full",  int'(bus.fifo_Full), 1);
        chk("wrap_level", int'(bus.w_Level),   8);

        // Simultaneous write and read at level 7.
        bus.w_Inc = 0;
        set_rptr(9);
        step();
        chk("sim_pre_level", int'(bus.w_Level), 7);
        bus.w_Inc = 1;
        set_rptr(10);
        step();
        chk("sim_level", int'(bus.w_Level),   7);
        chk("sim_full",  int'(bus.fifo_Full), 0);

        // Asynchronous reset mid-burst, away from any clock edge.
        step();
        #2;
        w_Rst = 1'b0;
        #1;
        chk_reset("rst1");
        set_rptr(0);
        #2;
        w_Rst = 1'b1;
        chk("post_rst_en",   int'(bus.w_En),   1);
        chk("post_rst_addr", int'(bus.w_Addr), 0);
        step();
        chk("post_rst_addr1", int'(bus.w_Addr), 1);

        // Random traffic; the reader never passes the registered write count.
        for (int c = 0; c < 2000; c++) begin
            bus.w_Inc   = ($urandom_range(0, 3) != 0);
            bus.ovf_Clr = ($urandom_range(0, 15) == 0);
            if (rbin != m_wcnt && $urandom_range(0, 1) == 1) set_rptr(rbin + 1);
            if (c % 500 == 499) bus.af_Thresh = 4'($urandom_range(0, 9));
            step();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
